// File: rtl/system_memory_sequencer_if.sv
// ----------------------------------------------------------------------------
// system_memory_sequencer_if
//
// Purpose: bundles the host handshake and system-memory mode signals of the
// system memory sequencer into a single interface.
//
// Signals:
//   load_req, run_req, output_req  host requests, sampled only while idle
//   gen_count                      generation count captured with run_req
//   serial_valid                   host serial-in bit valid (load phase)
//   out_ready                      host accepts serial-out bit (output phase)
//   load_mode, run_mode,           mode strobes to the system memory
//   output_mode
//   out_valid                      serial-out from memory carries a valid bit
//   busy                           sequencer is not idle
//   done                           one-cycle completion pulse
//   gen_remaining                  generations left in the current run
//
// Modports:
//   master  host side: drives requests and handshakes
//   slave   sequencer side: drives modes and status
// ----------------------------------------------------------------------------
interface system_memory_sequencer_if #(
    parameter int unsigned GEN_WIDTH = 8
);
    logic                 load_req;
    logic                 run_req;
    logic                 output_req;
    logic [GEN_WIDTH-1:0] gen_count;
    logic                 serial_valid;
    logic                 out_ready;
    logic                 load_mode;
    logic                 run_mode;
    logic                 output_mode;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    logic [GEN_WIDTH-1:0] gen_remaining;

    modport master (
        output load_req, run_req, output_req, gen_count, serial_valid, out_ready,
        input  load_mode, run_mode, output_mode, out_valid, busy, done, gen_remaining
    );

    modport slave (
        input  load_req, run_req, output_req, gen_count, serial_valid, out_ready,
        output load_mode, run_mode, output_mode, out_valid, busy, done, gen_remaining
    );
endinterface

// File: rtl/system_memory_sequencer.sv
// ----------------------------------------------------------------------------
// system_memory_sequencer
//
// Purpose: control FSM driving the load / run / output mode inputs of the
// shared system memory. Converts single-cycle host requests into counted
// bursts: DATA_SIZE serial load shifts, N generation runs, DATA_SIZE serial
// output shifts, each finished by a one-cycle done pulse.
//
// Parameters:
//   DATA_SIZE  number of memory cells; serial shifts per load/output
//   GEN_WIDTH  width of the generation-count request
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      system_memory_sequencer_if.slave (requests, handshakes, modes,
//            out_valid, busy, done, gen_remaining)
//
// Optional feature (macro SYSTEM_MEMORY_SEQUENCER_AUTO_OUTPUT_EN):
//   defined     run completion goes straight to the output phase; only the end
//               of the output phase produces done
//   undefined   run completion returns to idle with done
// ----------------------------------------------------------------------------
module system_memory_sequencer #(
    parameter int unsigned DATA_SIZE = 25,
    parameter int unsigned GEN_WIDTH = 8
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    system_memory_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_SIZE + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_OUTPUT = 2'd3;

    logic [1:0]           r_state;
    logic [CntW-1:0]      r_bit_cnt;
    logic [GEN_WIDTH-1:0] r_gen_rem;
    logic                 r_done;
    logic                 r_out_valid;

    logic [1:0]           w_state_d;
    logic [CntW-1:0]      w_bit_cnt_d;
    logic [GEN_WIDTH-1:0] w_gen_rem_d;
    logic                 w_done_d;

    logic                 w_load_mode;
    logic                 w_run_mode;
    logic                 w_output_mode;
    logic                 w_cnt_last;
    logic                 w_run_last;

    // Modes are decoded from the registered state, so at most one is ever high.
    assign w_load_mode   = (r_state == ST_LOAD) && bus.serial_valid;
    assign w_run_mode    = (r_state == ST_RUN) && (r_gen_rem != '0);
    assign w_output_mode = (r_state == ST_OUTPUT) && bus.out_ready;

    assign w_cnt_last = (r_bit_cnt == CntW'(DATA_SIZE - 1));
    // A count of 0 or 1 remaining finishes the run on this edge.
    assign w_run_last = (r_gen_rem <= GEN_WIDTH'(1));

    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_gen_rem_d = r_gen_rem;
        w_done_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run_req) begin
                    w_state_d   = ST_RUN;
                    w_gen_rem_d = bus.gen_count;
                    w_bit_cnt_d = '0;
                end else if (bus.load_req) begin
                    w_state_d   = ST_LOAD;
                    w_bit_cnt_d = '0;
                end else if (bus.output_req) begin
                    w_state_d   = ST_OUTPUT;
                    w_bit_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (bus.serial_valid) begin
                    w_bit_cnt_d = r_bit_cnt + CntW'(1);
                    if (w_cnt_last) begin
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (r_gen_rem != '0) begin
                    w_gen_rem_d = r_gen_rem - GEN_WIDTH'(1);
                end
                if (w_run_last) begin
`ifdef SYSTEM_MEMORY_SEQUENCER_AUTO_OUTPUT_EN
                    w_state_d   = ST_OUTPUT;
                    w_bit_cnt_d = '0;
`else
                    w_state_d   = ST_IDLE;
                    w_done_d    = 1'b1;
`endif
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    w_bit_cnt_d = r_bit_cnt + CntW'(1);
                    // done lands in the same cycle as the final out_valid
                    if (w_cnt_last) begin
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_gen_rem   <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_gen_rem   <= w_gen_rem_d;
            r_done      <= w_done_d;
            // Memory serial-out updates on the edge, so valid trails the strobe.
            r_out_valid <= w_output_mode;
        end
    end

    assign bus.load_mode     = w_load_mode;
    assign bus.run_mode      = w_run_mode;
    assign bus.output_mode   = w_output_mode;
    assign bus.out_valid     = r_out_valid;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = r_done;
    assign bus.gen_remaining = r_gen_rem;

endmodule

// File: tb/tb_system_memory_sequencer.sv
// ----------------------------------------------------------------------------
// tb_system_memory_sequencer
//
// Operation-level reference: each operation task generates its own handshake
// pattern and derives the expected per-cycle outputs from the operation rules
// (count accepted bits, list generations), queueing one expectation per cycle.
// A negedge monitor pops and compares against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_system_memory_sequencer;

    localparam int unsigned DataSize = 5;
    localparam int unsigned GenWidth = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    system_memory_sequencer_if #(.GEN_WIDTH(GenWidth)) bus ();

    system_memory_sequencer #(
        .DATA_SIZE(DataSize),
        .GEN_WIDTH(GenWidth)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                load_mode;
        logic                run_mode;
        logic                output_mode;
        logic                out_valid;
        logic                busy;
        logic                done;
        logic [GenWidth-1:0] gen_rem;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t sample();
        vec_t v;
        v.load_mode   = bus.load_mode;
        v.run_mode    = bus.run_mode;
        v.output_mode = bus.output_mode;
        v.out_valid   = bus.out_valid;
        v.busy        = bus.busy;
        v.done        = bus.done;
        v.gen_rem     = bus.gen_remaining;
        return v;
    endfunction

    function automatic vec_t mk(logic lm, logic rm, logic om, logic ov, logic bz, logic dn,
                                int gen);
        vec_t v;
        v.load_mode   = lm;
        v.run_mode    = rm;
        v.output_mode = om;
        v.out_valid   = ov;
        v.busy        = bz;
        v.done        = dn;
        v.gen_rem     = GenWidth'(gen);
        return v;
    endfunction

    function automatic logic junk();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        vec_t e;
        vec_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual lm/rm/om/ov/busy/done/gen=%b%b%b%b%b%b/%0d required=%b%b%b%b%b%b/%0d",
                         $time, a.load_mode, a.run_mode, a.output_mode, a.out_valid, a.busy,
                         a.done, a.gen_rem, e.load_mode, e.run_mode, e.output_mode,
                         e.out_valid, e.busy, e.done, e.gen_rem);
            end
        end
    end

    task automatic set_in(logic lr, logic rr, logic orq, logic sv, logic rdy,
                          logic [GenWidth-1:0] gc);
        bus.load_req     = lr;
        bus.run_req      = rr;
        bus.output_req   = orq;
        bus.serial_valid = sv;
        bus.out_ready    = rdy;
        bus.gen_count    = gc;
    endtask

    task automatic cyc(vec_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 1'b0, junk(), junk(), GenWidth'($urandom));
            cyc(mk(0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    // Load: bits of pat are serial_valid, LSB first; ends after DataSize ones.
    task automatic op_load(logic [31:0] pat);
        int   ones = 0;
        int   i = 0;
        logic b;
        set_in(1'b1, 1'b0, junk(), 1'b0, 1'b0, GenWidth'($urandom));
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        while (ones < int'(DataSize)) begin
            b = (i < 32) ? pat[i] : 1'b1;
            set_in(junk(), junk(), junk(), b, junk(), GenWidth'($urandom));
            cyc(mk(b, 0, 0, 0, 1, 0, 0));
            ones += int'(b);
            i++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(mk(0, 0, 0, 0, 0, 1, 0));
    endtask

    // Readout phase: bits of pat are out_ready; valid trails ready by a cycle.
    task automatic out_phase(logic [31:0] pat);
        int   ones = 0;
        int   i = 0;
        logic b;
        logic prev = 1'b0;
        while (ones < int'(DataSize)) begin
            b = (i < 32) ? pat[i] : 1'b1;
            set_in(junk(), junk(), junk(), junk(), b, GenWidth'($urandom));
            cyc(mk(0, 0, b, prev, 1, 0, 0));
            prev = b;
            ones += int'(b);
            i++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(mk(0, 0, 0, prev, 0, 1, 0));
    endtask

    task automatic op_output(logic [31:0] pat);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, GenWidth'($urandom));
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        out_phase(pat);
    endtask

    task automatic op_run(int n, bit all_req);
        set_in(all_req | junk(), 1'b1, all_req | junk(), 1'b0, 1'b0, GenWidth'(n));
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        if (n == 0) begin
            set_in(junk(), junk(), junk(), junk(), junk(), GenWidth'($urandom));
            cyc(mk(0, 0, 0, 0, 1, 0, 0));
        end else begin
            for (int k = n; k >= 1; k--) begin
                set_in(junk(), junk(), junk(), junk(), junk(), GenWidth'($urandom));
                cyc(mk(0, 1, 0, 0, 1, 0, k));
            end
        end
`ifdef SYSTEM_MEMORY_SEQUENCER_AUTO_OUTPUT_EN
        out_phase($urandom);
`else
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(mk(0, 0, 0, 0, 0, 1, 0));
`endif
    endtask

    // Run of 5, async reset while 2 generations remain: idle, no done.
    task automatic op_run_reset();
        vec_t a;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, GenWidth'(5));
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        for (int k = 5; k >= 3; k--) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            cyc(mk(0, 1, 0, 0, 1, 0, k));
        end
        q.push_back(mk(0, 1, 0, 0, 1, 0, 2));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        a = sample();
        checks++;
        if (a !== mk(0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid_run actual=%b required=%b", a, mk(0, 0, 0, 0, 0, 0, 0));
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(2);
    endtask

    initial begin
        vec_t a;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        a = sample();
        checks++;
        if (a !== mk(0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_init actual=%b required=%b", a, mk(0, 0, 0, 0, 0, 0, 0));
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(2);

        op_load(32'hFFFF_FFFF);
        idle_cycles(1);
        op_load(32'b1101_1001);          // 1,0,0,1,1,0,1,1
        op_run(3, 1'b0);
        op_run(0, 1'b0);
        op_run(2, 1'b1);                 // all three requests together
        op_output(32'b11_1011);          // 1,1,0,1,1,1
        op_run(1, 1'b0);
        op_run_reset();
        op_run(255, 1'b0);

        for (int it = 0; it < 40; it++) begin
            idle_cycles(int'($urandom_range(0, 2)));
            case ($urandom_range(0, 2))
                0:       op_load($urandom);
                1:       op_run(int'($urandom_range(0, 6)), junk());
                default: op_output($urandom);
            endcase
        end
        idle_cycles(2);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
